complex_result_buffer: RTL and testbench



---
 rtl/complex_result_buffer.sv | 156 +++++++++++++++
 tb/tb_complex_result_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_result_buffer.sv
// complex_result_buffer: in-order result FIFO between the Complex ALU and writeback.
// Not-executed packets are dropped. An exception entry halts writeback after it
// retires, and the buffer stays halted until a flush or reset.
module complex_result_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 7,
  parameter int unsigned FLAG_W = 6,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [TAG_W-1:0]           in_tag_i,
  input  logic [2*DATA_W-1:0]        in_result_i,
  input  logic [FLAG_W-1:0]          in_flags_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [TAG_W-1:0]           wb_tag_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic [FLAG_W-1:0]          wb_flags_o,
  output logic                       exc_pending_o,
  output logic [TAG_W-1:0]           exc_tag_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned EntW = TAG_W + DATA_W + FLAG_W;

  localparam int unsigned FlagExecuted  = 2;
  localparam int unsigned FlagException = 1;

  typedef enum logic {StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [EntW-1:0]   mem_q [DEPTH];
  logic [EntW-1:0]   mem_d [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              exc_pending_q, exc_pending_d;
  logic [TAG_W-1:0]  exc_tag_q, exc_tag_d;

  logic [EntW-1:0]   head_ent;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_data;
  logic [FLAG_W-1:0] head_flags;
  logic              wb_valid;
  logic              push, write, pop;

  // Upper half of the ALU result is architecturally dead here.
  logic              unused_result_hi;
  assign unused_result_hi = ^in_result_i[2*DATA_W-1:DATA_W];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake decode and show-ahead head entry.
  always_comb begin
    head_ent   = mem_q[rd_ptr_q];
    head_tag   = head_ent[EntW-1 -: TAG_W];
    head_data  = head_ent[FLAG_W +: DATA_W];
    head_flags = head_ent[FLAG_W-1:0];
    wb_valid   = (state_q == StRun) && (count_q != '0);
    push       = in_valid_i && in_ready_q;
    // A flush discards any simultaneous push, so nothing is written.
    write      = push && in_flags_i[FlagExecuted] && !flush_i;
    pop        = wb_valid && wb_ready_i;
  end

  // Next-state for storage, pointers, occupancy and the RUN/HALT machine.
  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    exc_pending_d = exc_pending_q;
    exc_tag_d     = exc_tag_q;

    if (write) begin
      mem_d[wr_ptr_q] = {in_tag_i, in_result_i[DATA_W-1:0], in_flags_i};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({write, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // The exception entry itself retires; writeback stops after it.
    if (pop && head_flags[FlagException]) begin
      state_d       = StHalt;
      exc_pending_d = 1'b1;
      exc_tag_d     = head_tag;
    end

    if (flush_i) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      state_d       = StRun;
      exc_pending_d = 1'b0;
      exc_tag_d     = '0;
    end

    // Registered ready ignores same-cycle pops to keep wb_ready_i off this path.
    in_ready_d = !flush_i && (state_d == StRun) && (count_d < CntW'(DEPTH));
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StRun;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b0;
      exc_pending_q <= 1'b0;
      exc_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      exc_pending_q <= exc_pending_d;
      exc_tag_q     <= exc_tag_d;
    end
  end

  // Entry storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output drive; head fields forced to zero when nothing is valid.
  always_comb begin
    in_ready_o    = in_ready_q;
    wb_valid_o    = wb_valid;
    wb_tag_o      = wb_valid ? head_tag : '0;
    wb_data_o     = wb_valid ? head_data : '0;
    wb_flags_o    = wb_valid ? head_flags : '0;
    exc_pending_o = exc_pending_q;
    exc_tag_o     = exc_tag_q;
    count_o       = count_q;
  end

endmodule

// File: tb/tb_complex_result_buffer.sv
// Bench for complex_result_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_complex_result_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  in_tag_i;
  logic [63:0] in_result_i;
  logic [5:0]  in_flags_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [6:0]  wb_tag_o;
  logic [31:0] wb_data_o;
  logic [5:0]  wb_flags_o;
  logic        exc_pending_o;
  logic [6:0]  exc_tag_o;
  logic [2:0]  count_o;

  complex_result_buffer #(
    .DATA_W(32),
    .TAG_W (7),
    .FLAG_W(6),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_tag_i     (in_tag_i),
    .in_result_i  (in_result_i),
    .in_flags_i   (in_flags_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_tag_o     (wb_tag_o),
    .wb_data_o    (wb_data_o),
    .wb_flags_o   (wb_flags_o),
    .exc_pending_o(exc_pending_o),
    .exc_tag_o    (exc_tag_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  tag;
    logic [31:0] data;
    logic [5:0]  flags;
  } ent_t;

  // Reference model state (post-edge view).
  ent_t       mq[$];
  logic       m_halted = 1'b0;
  logic [6:0] m_etag   = '0;
  logic       m_rdy    = 1'b0;

  logic [6:0] dut_log[$];
  bit         check_en = 0;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO queue, halted flag, registered ready.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset || flush_i) begin
        mq.delete();
        m_halted = 1'b0;
        m_etag   = '0;
        m_rdy    = 1'b0;
      end else begin
        automatic bit   do_push = in_valid_i && m_rdy;
        automatic bit   do_pop  = !m_halted && (mq.size() > 0) && wb_ready_i;
        automatic ent_t e;
        if (do_pop) begin
          e = mq.pop_front();
          if (e.flags[1]) begin
            m_halted = 1'b1;
            m_etag   = e.tag;
          end
        end
        if (do_push && in_flags_i[2]) begin
          mq.push_back('{tag: in_tag_i, data: in_result_i[31:0], flags: in_flags_i});
        end
        m_rdy = !m_halted && (mq.size() < DEPTH);
      end
    end
  end

  // Per-cycle comparison against the model, plus writeback log capture.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        automatic bit ev = !m_halted && (mq.size() > 0);
        chk("wb_valid", wb_valid_o, ev);
        chk("count", count_o, mq.size());
        chk("in_ready", in_ready_o, m_rdy);
        chk("exc_pending", exc_pending_o, m_halted);
        chk("exc_tag", exc_tag_o, m_etag);
        if (ev) begin
          chk("wb_tag", wb_tag_o, mq[0].tag);
          chk("wb_data", wb_data_o, mq[0].data);
          chk("wb_flags", wb_flags_o, mq[0].flags);
        end
        if (wb_valid_o && wb_ready_i) dut_log.push_back(wb_tag_o);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic v, input logic [6:0] t, input logic [63:0] r,
                        input logic [5:0] f);
    in_valid_i  = v;
    in_tag_i    = t;
    in_result_i = r;
    in_flags_i  = f;
  endtask

  initial begin
    reset      = 1'b0;
    flush_i    = 1'b0;
    wb_ready_i = 1'b0;
    set_in(1'b0, '0, '0, '0);

    // Reset held two cycles.
    cyc(1);
    check_en = 1;
    cyc(1);
    chk("rst_count", count_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_exc", exc_pending_o, 0);
    chk("rst_in_ready", in_ready_o, 0);
    reset = 1'b1;
    cyc(1);
    chk("post_rst_in_ready", in_ready_o, 1);

    // Fill with writeback stalled.
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, 7'(i), 64'(i * 16), 6'b001100);
      cyc(1);
    end
    set_in(1'b0, '0, '0, '0);
    chk("fill_count", count_o, 4);
    chk("fill_in_ready", in_ready_o, 0);
    chk("fill_head_tag", wb_tag_o, 1);
    chk("fill_head_data", wb_data_o, 32'h10);
    cyc(2);
    chk("stall_head_tag", wb_tag_o, 1);

    // Full boundary: pop while full, offered push must be refused.
    wb_ready_i = 1'b1;
    set_in(1'b1, 7'd20, 64'h20, 6'b001100);
    cyc(1);
    set_in(1'b0, '0, '0, '0);
    chk("full_pop_count", count_o, 3);
    chk("full_pop_in_ready", in_ready_o, 1);
    cyc(3);
    chk("drained_count", count_o, 0);

    // Streaming with pointer wrap.
    dut_log.delete();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 7'(i), 64'(32'h100 + i), 6'b000100);
      cyc(1);
    end
    set_in(1'b0, '0, '0, '0);
    cyc(2);
    chk("stream_len", dut_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk("stream_tag", (i < dut_log.size()) ? dut_log[i] : 7'h7f, i);
    end

    // Upper half of result discarded.
    wb_ready_i = 1'b0;
    set_in(1'b1, 7'd3, 64'hDEADBEEF_00000005, 6'b000100);
    cyc(1);
    set_in(1'b0, '0, '0, '0);
    chk("upper_valid", wb_valid_o, 1);
    chk("upper_data", wb_data_o, 32'h5);
    wb_ready_i = 1'b1;
    cyc(1);

    // Not-executed packet dropped.
    dut_log.delete();
    set_in(1'b1, 7'd9, 64'h99, 6'b001011);
    cyc(1);
    set_in(1'b0, '0, '0, '0);
    cyc(1);
    chk("drop_count", count_o, 0);
    chk("drop_log", dut_log.size(), 0);

    // Exception halt.
    wb_ready_i = 1'b0;
    set_in(1'b1, 7'd5, 64'h55, 6'b000110);
    cyc(1);
    set_in(1'b1, 7'd6, 64'h66, 6'b000100);
    cyc(1);
    set_in(1'b1, 7'd7, 64'h77, 6'b000100);
    cyc(1);
    set_in(1'b0, '0, '0, '0);
    dut_log.delete();
    wb_ready_i = 1'b1;
    cyc(1);
    chk("exc_wb_len", dut_log.size(), 1);
    chk("exc_wb_tag", (dut_log.size() > 0) ? dut_log[0] : 7'h7f, 5);
    chk("exc_pending", exc_pending_o, 1);
    chk("exc_tag", exc_tag_o, 5);
    chk("exc_wb_valid", wb_valid_o, 0);
    chk("exc_count", count_o, 2);
    cyc(2);
    chk("halt_held_count", count_o, 2);
    chk("halt_log", dut_log.size(), 1);
    flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_exc", exc_pending_o, 0);
    chk("flush_exc_tag", exc_tag_o, 0);
    chk("flush_in_ready", in_ready_o, 0);
    cyc(1);
    chk("flush_in_ready_next", in_ready_o, 1);

    // Flush colliding with push and pop.
    wb_ready_i = 1'b0;
    for (int i = 10; i <= 12; i++) begin
      set_in(1'b1, 7'(i), 64'(i), 6'b000101);
      cyc(1);
    end
    chk("coll_pre_count", count_o, 3);
    set_in(1'b1, 7'd13, 64'hD, 6'b000100);
    wb_ready_i = 1'b1;
    flush_i    = 1'b1;
    cyc(1);
    flush_i = 1'b0;
    set_in(1'b0, '0, '0, '0);
    dut_log.delete();
    chk("coll_count", count_o, 0);
    chk("coll_wb_valid", wb_valid_o, 0);
    cyc(3);
    chk("coll_log", dut_log.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
